// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: six-state one-hot ring plus opcode decoder producing the
// 12-bit control word for the W-bus datapath; latches a halted flag on HLT.
module controller_sequencer (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] IR_op,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm_,
  output logic       CE_,
  output logic       Li_,
  output logic       Ei_,
  output logic       La_,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb_,
  output logic       Lo_,
  output logic       HLT,
  output logic [5:0] T
);

  localparam logic [3:0] OpLda = 4'h0;
  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpSub = 4'h2;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [5:0] {
    StT1 = 6'b000001,
    StT2 = 6'b000010,
    StT3 = 6'b000100,
    StT4 = 6'b001000,
    StT5 = 6'b010000,
    StT6 = 6'b100000
  } ring_e;

  ring_e t_q, t_d;
  logic  halted_q, halted_d;

  // Decoded ring position; all zero when the ring holds an illegal (faulted) value.
  logic t1, t2, t3, t4, t5, t6, t_legal;

  always_comb begin
    t1      = 1'b0;
    t2      = 1'b0;
    t3      = 1'b0;
    t4      = 1'b0;
    t5      = 1'b0;
    t6      = 1'b0;
    t_legal = 1'b1;
    unique case (t_q)
      StT1:    t1 = 1'b1;
      StT2:    t2 = 1'b1;
      StT3:    t3 = 1'b1;
      StT4:    t4 = 1'b1;
      StT5:    t5 = 1'b1;
      StT6:    t6 = 1'b1;
      default: t_legal = 1'b0;
    endcase
  end

  logic is_lda, is_add, is_sub, is_out, is_hlt, is_arith, is_mem;

  always_comb begin
    is_lda   = (IR_op == OpLda);
    is_add   = (IR_op == OpAdd);
    is_sub   = (IR_op == OpSub);
    is_out   = (IR_op == OpOut);
    is_hlt   = (IR_op == OpHlt);
    is_arith = is_add | is_sub;
    is_mem   = is_lda | is_arith;
  end

  // Next state: advance the ring, freeze when halted, recover illegal values to T1.
  always_comb begin
    t_d      = t_q;
    halted_d = halted_q;
    if (!t_legal) begin
      t_d = StT1;
    end else if (!halted_q) begin
      unique case (t_q)
        StT1:    t_d = StT2;
        StT2:    t_d = StT3;
        StT3:    t_d = StT4;
        StT4:    t_d = StT5;
        StT5:    t_d = StT6;
        StT6:    t_d = StT1;
        default: t_d = StT1;
      endcase
      if (t4 && is_hlt) begin
        halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      t_q      <= StT1;
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      halted_q <= halted_d;
    end
  end

  // Control word: every term is gated so reset and halt force the inactive word.
  logic en;

  always_comb begin
    en  = ~CLR & ~halted_q & t_legal;
    Cp  = en & t2;
    Ep  = en & t1;
    Lm_ = ~(en & (t1 | (t4 & is_mem)));
    CE_ = ~(en & (t3 | (t5 & is_mem)));
    Li_ = ~(en & t3);
    Ei_ = ~(en & t4 & is_mem);
    La_ = ~(en & ((t5 & is_lda) | (t6 & is_arith)));
    Ea  = en & t4 & is_out;
    Su  = en & t6 & is_sub;
    Eu  = en & t6 & is_arith;
    Lb_ = ~(en & t5 & is_arith);
    Lo_ = ~(en & t4 & is_out);
  end

  assign HLT = halted_q;
  assign T   = t_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Bench for controller_sequencer: directed and random opcode/reset streams checked each cycle
// against a microcode-table reference model.
module tb_controller_sequencer;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [3:0] IR_op;
  logic       Cp, Ep, Lm_, CE_, Li_, Ei_, La_, Ea, Su, Eu, Lb_, Lo_, HLT;
  logic [5:0] T;

  controller_sequencer dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .IR_op (IR_op),
    .Cp    (Cp),
    .Ep    (Ep),
    .Lm_   (Lm_),
    .CE_   (CE_),
    .Li_   (Li_),
    .Ei_   (Ei_),
    .La_   (La_),
    .Ea    (Ea),
    .Su    (Su),
    .Eu    (Eu),
    .Lb_   (Lb_),
    .Lo_   (Lo_),
    .HLT   (HLT),
    .T     (T)
  );

  always #5 CLK = ~CLK;

  // Word bit positions: {Cp,Ep,Lm_,CE_,Li_,Ei_,La_,Ea,Su,Eu,Lb_,Lo_}
  localparam int CP = 11, EP = 10, LM = 9, CE = 8, LI = 7, EI = 6;
  localparam int LA = 5, EA = 4, SU = 3, EU = 2, LB = 1, LO = 0;
  localparam logic [11:0] Inactive = 12'h3E3;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: step 0..5 is T1..T6.
  int m_step;
  bit m_halt;

  function automatic logic [11:0] exp_word(int step, logic [3:0] op, bit clr, bit halt);
    logic [11:0] w;
    w = Inactive;
    if (clr || halt) return w;
    case (step)
      0: begin w[EP] = 1'b1; w[LM] = 1'b0; end
      1: w[CP] = 1'b1;
      2: begin w[CE] = 1'b0; w[LI] = 1'b0; end
      default: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
          if (step == 3) begin w[EI] = 1'b0; w[LM] = 1'b0; end
          if (step == 4) begin
            w[CE] = 1'b0;
            if (op == 4'h0) w[LA] = 1'b0;
            else            w[LB] = 1'b0;
          end
          if (step == 5 && op != 4'h0) begin
            w[EU] = 1'b1;
            w[LA] = 1'b0;
            w[SU] = (op == 4'h2);
          end
        end else if (op == 4'hE && step == 3) begin
          w[EA] = 1'b1;
          w[LO] = 1'b0;
        end
      end
    endcase
    return w;
  endfunction

  task automatic check_cycle(input bit clr, input logic [3:0] op);
    logic [11:0] got, exp;
    logic [5:0]  exp_t;
    logic [4:0]  drivers;
    got     = {Cp, Ep, Lm_, CE_, Li_, Ei_, La_, Ea, Su, Eu, Lb_, Lo_};
    exp     = exp_word(m_step, op, clr, m_halt);
    exp_t   = 6'b000001 << m_step;
    drivers = {Ep, ~CE_, ~Ei_, Ea, Eu};

    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL word step=%0d op=%h clr=%0d got=%h exp=%h", m_step, op, clr, got, exp);
    end
    n_checks++;
    assert (T === exp_t) else begin
      n_fail++;
      $error("FAIL ring T got=%b exp=%b", T, exp_t);
    end
    n_checks++;
    assert (HLT === m_halt) else begin
      n_fail++;
      $error("FAIL hlt_flag got=%b exp=%b", HLT, m_halt);
    end
    n_checks++;
    assert ($countones(drivers) <= 1) else begin
      n_fail++;
      $error("FAIL bus_contention drivers=%b exp=at most one", drivers);
    end
    n_checks++;
    assert ($onehot(T)) else begin
      n_fail++;
      $error("FAIL ring_onehot T=%b exp=one-hot", T);
    end
  endtask

  // One clock: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic cyc(input bit clr, input logic [3:0] op);
    @(negedge CLK);
    CLR   = clr;
    IR_op = op;
    #1;
    check_cycle(clr, op);
    @(posedge CLK);
    if (clr) begin
      m_step = 0;
      m_halt = 1'b0;
    end else if (!m_halt) begin
      if (m_step == 3 && op == 4'hF) m_halt = 1'b1;
      m_step = (m_step + 1) % 6;
    end
  endtask

  task automatic instr(input logic [3:0] op);
    for (int i = 0; i < 6; i++) cyc(1'b0, op);
  endtask

  initial begin
    CLR   = 1'b1;
    IR_op = 4'h0;
    @(posedge CLK);
    m_step = 0;
    m_halt = 1'b0;

    // Reset held two cycles, then the opcode mix.
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'h0);
    instr(4'h0);
    instr(4'h1);
    instr(4'h2);
    instr(4'hE);
    instr(4'h5);

    // Halt, then opcode noise must be ignored while frozen.
    instr(4'hF);
    for (int i = 0; i < 22; i++) cyc(1'b0, 4'($urandom));
    cyc(1'b1, 4'h0);

    // Abort an ADD in T5.
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'h1);
    cyc(1'b1, 4'h1);
    instr(4'h1);

    // Sweep every opcode through a full instruction.
    for (int op = 0; op < 16; op++) begin
      instr(4'(op));
      if (op == 15) begin
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'h0);
        cyc(1'b1, 4'h0);
      end
    end

    // Random opcodes every cycle with occasional reset.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 24) == 0), 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
